// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, beat counts, port indices.
package mem_port_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int BEATS_WORD = 4;
  localparam int BEATS_BYTE = 1;

  localparam logic P_CORE = 1'b0;
  localparam logic P_AUX  = 1'b1;

  // Index of the final beat of a transfer.
  function automatic logic [1:0] last_beat(input logic word);
    return word ? 2'(BEATS_WORD - 1) : 2'(BEATS_BYTE - 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: combinational one-hot grant, pointer = last served port.
// Zero latency; a losing request simply stays pending until the pointer favours it.
module rr_arb2
  import mem_port_arbiter_pkg::*;
#(
  parameter bit FIRST0 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_port,
  output logic [1:0] gnt
);

  logic last;

  // Pointer starts on the port that should lose the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= FIRST0 ? P_AUX : P_CORE;
    end else if (upd) begin
      last <= upd_port;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == P_AUX) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide memory port between two requesters; words run as 4 big-endian byte beats.
// gnt 1 cycle after req is sampled, done N+1 cycles after; a loser holds req until granted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit PRIO0_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic               word0,
  input  logic               word1,
  input  logic [WIDTH-1:0]   adr0,
  input  logic [WIDTH-1:0]   adr1,
  input  logic [4*WIDTH-1:0] wdata0,
  input  logic [4*WIDTH-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [4*WIDTH-1:0] rdata0,
  output logic [4*WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0]   adr,
  output logic [WIDTH-1:0]   writedata,
  output logic               memwrite,
  input  logic [WIDTH-1:0]   memdata
);

  typedef struct packed {
    logic               port;
    logic               we;
    logic               word;
    logic [WIDTH-1:0]   base;
    logic [4*WIDTH-1:0] wdata;
  } cmd_t;

  logic [1:0]         state;
  cmd_t               cmd;
  cmd_t               cmd_nxt;
  logic [1:0]         beat;
  logic [1:0]         pick;
  logic [4*WIDTH-1:0] rbuf;
  logic [4*WIDTH-1:0] rd_merged;

  // Beat address stays inside the aligned word: the low two bits wrap, never carry.
  function automatic logic [WIDTH-1:0] beat_adr(input cmd_t c, input logic [1:0] k);
    return {c.base[WIDTH-1:2], c.base[1:0] + k};
  endfunction

  function automatic logic [WIDTH-1:0] beat_byte(input cmd_t c, input logic [1:0] k);
    return c.word ? c.wdata[(3 - int'(k))*WIDTH +: WIDTH] : c.wdata[WIDTH-1:0];
  endfunction

  rr_arb2 #(.FIRST0(PRIO0_FIRST)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      ({req1, req0}),
    .upd      (state == DONE),
    .upd_port (cmd.port),
    .gnt      (pick)
  );

  always_comb begin
    cmd_nxt       = cmd;
    cmd_nxt.port  = pick[1];
    cmd_nxt.we    = pick[1] ? we1    : we0;
    cmd_nxt.word  = pick[1] ? word1  : word0;
    cmd_nxt.base  = pick[1] ? adr1   : adr0;
    cmd_nxt.wdata = pick[1] ? wdata1 : wdata0;
    if (cmd_nxt.word) begin
      cmd_nxt.base[1:0] = 2'b00;
    end
  end

  // Read byte of the current beat merged into its lane; byte reads use lane 0.
  always_comb begin
    int lane;
    lane      = cmd.word ? (3 - int'(beat)) : 0;
    rd_merged = rbuf;
    rd_merged[lane*WIDTH +: WIDTH] = memdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cmd       <= '0;
      beat      <= 2'd0;
      rbuf      <= '0;
      adr       <= '0;
      writedata <= '0;
      memwrite  <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (|pick) begin
            cmd       <= cmd_nxt;
            beat      <= 2'd0;
            rbuf      <= '0;
            adr       <= beat_adr(cmd_nxt, 2'd0);
            writedata <= beat_byte(cmd_nxt, 2'd0);
            memwrite  <= cmd_nxt.we;
            gnt0      <= pick[0];
            gnt1      <= pick[1];
            state     <= XFER;
          end
        end
        XFER: begin
          if (!cmd.we) begin
            rbuf <= rd_merged;
          end
          if (beat == last_beat(cmd.word)) begin
            memwrite <= 1'b0;
            done0    <= (cmd.port == P_CORE);
            done1    <= (cmd.port == P_AUX);
            // rdata only changes at completion so it stays stable between dones.
            if (!cmd.we && cmd.port == P_CORE) begin
              rdata0 <= rd_merged;
            end
            if (!cmd.we && cmd.port == P_AUX) begin
              rdata1 <= rd_merged;
            end
            state <= DONE;
          end else begin
            beat      <= beat + 2'd1;
            adr       <= beat_adr(cmd, beat + 2'd1);
            writedata <= beat_byte(cmd, beat + 2'd1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model expanded to expected cycles,
// compared every cycle, plus literal expectations for the directed scenarios.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        preload;
  logic        req_a  [2];
  logic        we_a   [2];
  logic        word_a [2];
  logic [7:0]  adr_a  [2];
  logic [31:0] wd_a   [2];
  logic        gnt0, gnt1, done0, done1, memwrite;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  adr, writedata, memdata;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.WIDTH(8), .PRIO0_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0(req_a[0]), .req1(req_a[1]), .we0(we_a[0]), .we1(we_a[1]),
    .word0(word_a[0]), .word1(word_a[1]), .adr0(adr_a[0]), .adr1(adr_a[1]),
    .wdata0(wd_a[0]), .wdata1(wd_a[1]),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .adr(adr), .writedata(writedata), .memwrite(memwrite), .memdata(memdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- external memory ----------------
  logic [7:0] mem [256];

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h10:    return 8'h11;
      'h11:    return 8'h22;
      'h12:    return 8'h33;
      'h13:    return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
    end else if (memwrite) begin
      mem[adr] <= writedata;
    end
  end
  assign memdata = mem[adr];

  // ---------------- reference model ----------------
  typedef struct {
    logic        g0, g1, d0, d1, mw;
    logic [7:0]  a, wd;
    logic [31:0] r0, r1;
  } cyc_t;

  cyc_t        q[$];
  logic [7:0]  ref_mem [256];
  logic [7:0]  held_a;
  logic [31:0] held_r0, held_r1;
  int          last_srv;

  function automatic cyc_t idle_rec();
    cyc_t c;
    c.g0 = 0; c.g1 = 0; c.d0 = 0; c.d1 = 0; c.mw = 0;
    c.a = held_a; c.wd = 8'h00; c.r0 = held_r0; c.r1 = held_r1;
    return c;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      held_a = 8'h00; held_r0 = 0; held_r1 = 0;
      last_srv = 1;
      if (preload) for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    end else if (q.size() != 0) begin
      cyc_t c;
      c = q.pop_front();
      if (c.mw) ref_mem[c.a] = c.wd;
      held_a = c.a; held_r0 = c.r0; held_r1 = c.r1;
      if (c.d0) last_srv = 0;
      if (c.d1) last_srv = 1;
    end else if (req_a[0] || req_a[1]) begin
      int p, n;
      logic [7:0] base;
      logic [31:0] res;
      cyc_t c;
      p = (req_a[0] && req_a[1]) ? (last_srv == 0 ? 1 : 0) : (req_a[1] ? 1 : 0);
      n = word_a[p] ? 4 : 1;
      base = word_a[p] ? (adr_a[p] & 8'hFC) : adr_a[p];
      res = word_a[p] ? {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]}
                      : {24'h0, ref_mem[base]};
      for (int k = 0; k < n; k++) begin
        c.g0 = (k == 0 && p == 0); c.g1 = (k == 0 && p == 1);
        c.d0 = 0; c.d1 = 0; c.mw = we_a[p];
        c.a  = base + 8'(k);
        c.wd = word_a[p] ? 8'(wd_a[p] >> (8 * (3 - k))) : wd_a[p][7:0];
        c.r0 = held_r0; c.r1 = held_r1;
        q.push_back(c);
      end
      c.g0 = 0; c.g1 = 0; c.mw = 0;
      c.d0 = (p == 0); c.d1 = (p == 1);
      c.a  = base + 8'(n - 1);
      c.r0 = (p == 0 && !we_a[p]) ? res : held_r0;
      c.r1 = (p == 1 && !we_a[p]) ? res : held_r1;
      q.push_back(c);
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int gcnt[2], dcnt[2], mwcnt, both_gnt;
  int gnt_log[$];
  logic [15:0] wlog[$];

  always @(negedge clk) begin
    cyc_t e;
    e = (q.size() != 0) ? q[0] : idle_rec();
    checks++;
    if (gnt0 !== e.g0 || gnt1 !== e.g1 || done0 !== e.d0 || done1 !== e.d1 ||
        memwrite !== e.mw || adr !== e.a || (e.mw && writedata !== e.wd) ||
        rdata0 !== e.r0 || rdata1 !== e.r1) begin
      errors++;
      $display("FAIL cycle t=%0t got gnt=%b%b done=%b%b mw=%b adr=%h wd=%h r0=%h r1=%h want gnt=%b%b done=%b%b mw=%b adr=%h wd=%h r0=%h r1=%h",
               $time, gnt1, gnt0, done1, done0, memwrite, adr, writedata, rdata0, rdata1,
               e.g1, e.g0, e.d1, e.d0, e.mw, e.a, e.wd, e.r0, e.r1);
    end
    if (gnt0) begin gcnt[0]++; gnt_log.push_back(0); end
    if (gnt1) begin gcnt[1]++; gnt_log.push_back(1); end
    if (done0) dcnt[0]++;
    if (done1) dcnt[1]++;
    if (gnt0 && gnt1) both_gnt++;
    if (memwrite) begin mwcnt++; wlog.push_back({adr, writedata}); end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? gnt0 : gnt1;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 0) ? done0 : done1;
  endfunction

  // Request, wait for gnt, drop req, then count cycles from gnt to done.
  task automatic xfer(input int p, input logic we, input logic word, input logic [7:0] a,
                      input logic [31:0] wd, output int lat);
    bit ok;
    @(posedge clk); #1;
    req_a[p] = 1'b1; we_a[p] = we; word_a[p] = word; adr_a[p] = a; wd_a[p] = wd;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = gnt_of(p);
    end
    @(posedge clk); #1;
    req_a[p] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL gnt_timeout port=%0d got=no gnt want=gnt within 40 cycles", p);
    end
    lat = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      lat++;
      ok = done_of(p);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout port=%0d got=no done want=done within 20 cycles", p);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, g1_before, d0_before, mw_before;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      req_a[p] = 0; we_a[p] = 0; word_a[p] = 0; adr_a[p] = 0; wd_a[p] = 0;
    end
    preload = 1'b1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {59'd0, memwrite, gnt0, gnt1, done0, done1}, 64'd0);
    check("reset_adr_rdata", {adr, rdata0, 24'd0} | {32'd0, rdata1}, 64'd0);
    @(posedge clk); #1;
    preload = 1'b0;
    reset = 1'b1;

    // Contention: both hold requests for two transfers each.
    gnt_log.delete();
    fork
      begin int l; xfer(0, 0, 0, 8'h10, 0, l); xfer(0, 0, 0, 8'h10, 0, l); end
      begin int l; xfer(1, 0, 0, 8'h11, 0, l); xfer(1, 0, 0, 8'h11, 0, l); end
    join
    check("rr_count", 64'(gnt_log.size()), 64'd4);
    if (gnt_log.size() == 4)
      check("rr_order", {gnt_log[0][3:0], gnt_log[1][3:0], gnt_log[2][3:0], gnt_log[3][3:0]}, 64'h0101);
    check("rr_rdata0", rdata0, 64'h11);
    check("rr_rdata1", rdata1, 64'h22);

    // Word read of unaligned address 0x12.
    xfer(0, 0, 1, 8'h12, 0, lat);
    check("word_read_lat", lat, 4);
    check("word_read_data", rdata0, 64'h11223344);

    // Byte write then byte read of 0x20 on port 1.
    mw_before = mwcnt;
    wlog.delete();
    xfer(1, 1, 0, 8'h20, 32'hFFFF_FFA5, lat);
    check("byte_write_beats", mwcnt - mw_before, 1);
    if (wlog.size() > 0) check("byte_write_bus", wlog[0], 16'h20A5);
    xfer(1, 0, 0, 8'h20, 0, lat);
    check("byte_read_lat", lat, 1);
    check("byte_read_data", rdata1, 64'h0000_00A5);

    // Word write, beats in big-endian order.
    wlog.delete();
    xfer(0, 1, 1, 8'h30, 32'hDEADBEEF, lat);
    check("word_write_beats", 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4)
      check("word_write_order", {wlog[0], wlog[1], wlog[2], wlog[3]}, 64'h30DE_31AD_32BE_33EF);
    check("word_write_mem", {mem[8'h30], mem[8'h31], mem[8'h32], mem[8'h33]}, 64'hDEADBEEF);

    // Reset asserted in the middle of beat 2 of a word write.
    @(posedge clk); #1;
    req_a[0] = 1; we_a[0] = 1; word_a[0] = 1; adr_a[0] = 8'h40; wd_a[0] = 32'h01020304;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = gnt0;
    end
    check("abort_gnt_seen", 64'(ok), 64'd1);
    @(posedge clk); #1;
    req_a[0] = 0;
    @(posedge clk); #2;
    d0_before = dcnt[0];
    reset = 1'b0;
    #1;
    check("abort_memwrite_low", 64'(memwrite), 64'd0);
    repeat (3) @(negedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_done", dcnt[0] - d0_before, 0);
    check("abort_mem", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 64'h0102_0000);
    xfer(1, 0, 0, 8'h41, 0, lat);
    check("after_abort_read", rdata1, 64'h0000_0002);

    // One-cycle req1 pulse while port 0 is mid-transfer.
    g1_before = gcnt[1];
    mw_before = mwcnt;
    fork
      begin int l; xfer(0, 0, 1, 8'h10, 0, l); end
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(negedge clk);
          seen = gnt0;
        end
        @(posedge clk); #1;
        req_a[1] = 1; we_a[1] = 1; word_a[1] = 0; adr_a[1] = 8'h50; wd_a[1] = 32'h000000FF;
        @(posedge clk); #1;
        req_a[1] = 0;
      end
    join
    repeat (4) @(negedge clk);
    check("pulse_no_gnt1", gcnt[1] - g1_before, 0);
    check("pulse_no_write", mwcnt - mw_before, 0);
    check("pulse_mem", mem[8'h50], 8'h00);

    // Random concurrent traffic, checked by the per-cycle model.
    fork
      begin
        int l;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          xfer(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom, l);
        end
      end
      begin
        int l;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          xfer(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), $urandom, l);
        end
      end
    join
    repeat (4) @(negedge clk);

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
      check("final_mem_image_diffs", bad, 0);
    end
    check("never_both_gnt", both_gnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
